uart_rx_fifo: RTL and testbench

- Receive-side byte buffer that sits directly downstream of the UART receiver.
- Consumes the receiver's level-held `ready` flag and `data` byte, and returns a one-cycle `ready_clr` pulse for each byte taken.
- Stores bytes in a DEPTH-entry circular buffer and presents them to the host logic on a first-word-fall-through valid/ready read port.
- Flags any byte lost to a full buffer with a sticky overrun bit, because a UART line cannot be back-pressured.

---
 rtl/uart_rx_fifo_if.sv | 22 ++
 rtl/uart_rx_fifo.sv | 52 +++++
 tb/tb_uart_rx_fifo.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side and host read-side signals of the UART receive FIFO.
interface uart_rx_fifo_if #(parameter int ADDR_W = 4);
  logic [7:0] rx_data;
  logic rx_ready;
  logic rx_ready_clr;
  logic [7:0] rd_data;
  logic rd_valid;
  logic rd_ready;
  logic [ADDR_W:0] count;
  logic full;
  logic empty;
  logic overrun;
  logic overrun_clr;
  modport slave(
    input rx_data, rx_ready, rd_ready, overrun_clr,
    output rx_ready_clr, rd_data, rd_valid, count, full, empty, overrun
  );
  modport master(
    output rx_data, rx_ready, rd_ready, overrun_clr,
    input rx_ready_clr, rd_data, rd_valid, count, full, empty, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte buffer behind a UART receiver with FWFT read port and sticky overrun.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input logic clk_50m,
  input logic rst,
  uart_rx_fifo_if.slave bus
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  logic [7:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W:0] r_count;
  logic r_clr;
  logic r_ovr;
  logic w_take;
  logic w_pop;
  logic w_push;
  // The in-flight clear pulse masks the still-high receiver flag to avoid a double capture.
  always_comb begin
    w_take = bus.rx_ready & ~r_clr;
    w_pop = (r_count != '0) & bus.rd_ready;
    w_push = w_take & ((r_count != FULL_CNT) | w_pop);
  end
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
      r_clr <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_clr <= w_take;
      r_ovr <= (w_take & ~w_push) | (r_ovr & ~bus.overrun_clr);
      if (w_push) begin
        r_mem[r_wr] <= bus.rx_data;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_pop};
    end
  end
  assign bus.rx_ready_clr = r_clr;
  assign bus.rd_data = r_mem[r_rd];
  assign bus.rd_valid = r_count != '0;
  assign bus.count = r_count;
  assign bus.full = r_count == FULL_CNT;
  assign bus.empty = r_count == '0;
  assign bus.overrun = r_ovr;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios for uart_rx_fifo with a behavioural UART receiver flag.
module tb_uart_rx_fifo;
  logic clk_50m = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  uart_rx_fifo_if #(.ADDR_W(4)) bus();
  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut(.clk_50m(clk_50m), .rst(rst), .bus(bus));
  always #10 clk_50m = ~clk_50m;
  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask
  // Receiver model: hold the flag until the clear is seen, keep it through that cycle, then drop or reload.
  task automatic send(input logic [7:0] b, input bit hold);
    int t = 0;
    bus.rx_data = b;
    bus.rx_ready = 1'b1;
    do begin
      tick();
      t++;
    end while (!bus.rx_ready_clr && t < 8);
    n_cmp++;
    if (bus.rx_ready_clr !== 1'b1) begin n_err++; $display("FAIL send_clr_timeout byte=%02h got clr=%b want 1", b, bus.rx_ready_clr); end
    tick();
    if (!hold) bus.rx_ready = 1'b0;
  endtask
  task automatic pop1();
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
  endtask
  task automatic test_reset();
    #5;
    n_cmp++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_err++; $display("FAIL rst_flags got empty=%b full=%b want 1 0", bus.empty, bus.full); end
    n_cmp++; if (bus.rd_data !== 8'h00) begin n_err++; $display("FAIL rst_data got %02h want 00", bus.rd_data); end
    n_cmp++; if (bus.overrun !== 1'b0 || bus.rx_ready_clr !== 1'b0) begin n_err++; $display("FAIL rst_ovr_clr got ovr=%b clr=%b want 0 0", bus.overrun, bus.rx_ready_clr); end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic test_single();
    send(8'hA5, 1'b0);
    n_cmp++; if (bus.rx_ready_clr !== 1'b0) begin n_err++; $display("FAIL single_pulse_width got clr=%b want 0", bus.rx_ready_clr); end
    n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin n_err++; $display("FAIL single_head got v=%b d=%02h want 1 a5", bus.rd_valid, bus.rd_data); end
    tick();
    n_cmp++; if (bus.count !== 5'd1) begin n_err++; $display("FAIL single_count got %0d want 1", bus.count); end
    pop1();
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL single_empty got %b want 1", bus.empty); end
  endtask
  task automatic test_full_overrun();
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    n_cmp++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin n_err++; $display("FAIL fill_full got full=%b count=%0d want 1 16", bus.full, bus.count); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL fill_no_ovr got %b want 0", bus.overrun); end
    send(8'hFF, 1'b0);
    n_cmp++; if (bus.overrun !== 1'b1 || bus.count !== 5'd16) begin n_err++; $display("FAIL drop_ovr got ovr=%b count=%0d want 1 16", bus.overrun, bus.count); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.rd_data !== 8'(i)) begin n_err++; $display("FAIL drain_order[%0d] got %02h want %02h", i, bus.rd_data, 8'(i)); end
      pop1();
    end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", bus.empty); end
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear got %b want 0", bus.overrun); end
  endtask
  task automatic test_full_swap();
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    bus.rx_data = 8'h55;
    bus.rx_ready = 1'b1;
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    n_cmp++; if (bus.rx_ready_clr !== 1'b1) begin n_err++; $display("FAIL swap_clr got %b want 1", bus.rx_ready_clr); end
    tick();
    bus.rx_ready = 1'b0;
    n_cmp++; if (bus.count !== 5'd16 || bus.overrun !== 1'b0) begin n_err++; $display("FAIL swap_count got count=%0d ovr=%b want 16 0", bus.count, bus.overrun); end
    for (int i = 1; i < 17; i++) begin
      n_cmp++; if (bus.rd_data !== ((i == 16) ? 8'h55 : 8'(i))) begin n_err++; $display("FAIL swap_drain[%0d] got %02h want %02h", i, bus.rd_data, (i == 16) ? 8'h55 : 8'(i)); end
      pop1();
    end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL swap_empty got %b want 1", bus.empty); end
  endtask
  task automatic test_back_to_back();
    int maxc = 0;
    fork
      for (int i = 0; i < 40; i++) send(8'(16 + i), i != 39);
      for (int k = 0; k < 40; k++) begin
        int t = 0;
        while (!bus.rd_valid && t < 20) begin
          tick();
          t++;
          if (int'(bus.count) > maxc) maxc = int'(bus.count);
        end
        tick();
        if (int'(bus.count) > maxc) maxc = int'(bus.count);
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(16 + k)) begin n_err++; $display("FAIL stream[%0d] got v=%b d=%02h want 1 %02h", k, bus.rd_valid, bus.rd_data, 8'(16 + k)); end
        pop1();
      end
    join
    n_cmp++; if (maxc > 2) begin n_err++; $display("FAIL stream_maxcount got %0d want <=2", maxc); end
    n_cmp++; if (bus.overrun !== 1'b0 || bus.empty !== 1'b1) begin n_err++; $display("FAIL stream_end got ovr=%b empty=%b want 0 1", bus.overrun, bus.empty); end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 1'b0);
    n_cmp++; if (bus.count !== 5'd5) begin n_err++; $display("FAIL mid_count5 got %0d want 5", bus.count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00) begin n_err++; $display("FAIL mid_async got count=%0d v=%b d=%02h want 0 0 00", bus.count, bus.rd_valid, bus.rd_data); end
    bus.rx_data = 8'h3C;
    bus.rx_ready = 1'b1;
    tick();
    n_cmp++; if (bus.rx_ready_clr !== 1'b0 || bus.count !== 5'd0) begin n_err++; $display("FAIL mid_hold got clr=%b count=%0d want 0 0", bus.rx_ready_clr, bus.count); end
    rst = 1'b0;
    send(8'h3C, 1'b0);
    n_cmp++; if (bus.count !== 5'd1 || bus.rd_data !== 8'h3C) begin n_err++; $display("FAIL mid_capture got count=%0d d=%02h want 1 3c", bus.count, bus.rd_data); end
    pop1();
  endtask
  task automatic test_overrun_clr();
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b0);
    n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL oc_pre got %b want 0", bus.overrun); end
    bus.rx_data = 8'hEE;
    bus.rx_ready = 1'b1;
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    n_cmp++; if (bus.rx_ready_clr !== 1'b1 || bus.overrun !== 1'b1 || bus.count !== 5'd16) begin n_err++; $display("FAIL oc_set_wins got clr=%b ovr=%b count=%0d want 1 1 16", bus.rx_ready_clr, bus.overrun, bus.count); end
    tick();
    bus.rx_ready = 1'b0;
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL oc_clear got %b want 0", bus.overrun); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.rd_data !== 8'(8'h20 + i)) begin n_err++; $display("FAIL oc_drain[%0d] got %02h want %02h", i, bus.rd_data, 8'(8'h20 + i)); end
      pop1();
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.rx_data = 8'h00;
    bus.rx_ready = 1'b0;
    bus.rd_ready = 1'b0;
    bus.overrun_clr = 1'b0;
    test_reset();
    test_single();
    test_full_overrun();
    test_full_swap();
    test_back_to_back();
    test_reset_mid();
    test_overrun_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
